spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_clk_gen.sv | 58 +++++
 rtl/spi_master_ctrl.sv | 159 +++++++++++++++
 tb/tb_spi_master_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default constants for the SPI master controller.
package spi_pkg;

  localparam int unsigned SPI_DATA_WIDTH = 8;
  localparam int unsigned SPI_CLK_DIV    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV cycles while en is high and
// emits one-cycle strobes in the first cycle of each new sclk level.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Dropping en parks sclk low without producing a fall strobe.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
      rise_d = !sclk_q;
      fall_d = sclk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sclk     = sclk_q;
  assign rise_stb = rise_q;
  assign fall_stb = fall_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master draining a TX FIFO and filling an RX FIFO, MSB first.
// Optional SPI_CTRL_LOOPBACK_EN adds a loopback input that samples mosi instead of miso.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int unsigned CLK_DIV    = SPI_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
`ifdef SPI_CTRL_LOOPBACK_EN
  input  logic                  loopback,
`endif
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_empty,
  output logic                  tx_rd_en,
  output logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_full,
  output logic                  rx_wr_en,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  busy
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  spi_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]      done_cnt_q, done_cnt_d;
  logic                  tx_rd_en_q, tx_rd_en_d;
  logic                  rx_wr_en_q, rx_wr_en_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  mosi_q, mosi_d;
  logic                  clk_en_c;
  logic                  sample_bit_c;
  logic                  rise_stb;
  logic                  fall_stb;

`ifdef SPI_CTRL_LOOPBACK_EN
  assign sample_bit_c = loopback ? mosi_q : miso;
`else
  assign sample_bit_c = miso;
`endif

  // Divider also runs during LOAD so SHIFT ends on the cycle of the last fall.
  assign clk_en_c = (state_d == ST_SHIFT);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (clk_en_c),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    done_cnt_d = done_cnt_q;
    tx_rd_en_d = 1'b0;
    rx_wr_en_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && !tx_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (rise_stb) rx_shift_d = (rx_shift_q << 1) | DATA_WIDTH'(sample_bit_c);
        if (fall_stb) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) state_d = ST_STORE;
        end
      end
      ST_STORE: begin
        // Strobe is registered, so it lands one cycle after rx_full is seen low.
        if (!rx_full) begin
          rx_wr_en_d = 1'b1;
          rx_data_d  = rx_shift_q;
          done_cnt_d = '0;
          state_d    = (enable && !tx_empty) ? ST_LOAD : ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_cnt_q == DIV_W'(CLK_DIV - 1)) begin
          done_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          done_cnt_d = done_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_LOAD) begin
      tx_rd_en_d = 1'b1;
      shift_d    = tx_data;
      rx_shift_d = '0;
      bit_cnt_d  = '0;
    end

    cs_n_d = (state_d == ST_IDLE);
    busy_d = (state_d != ST_IDLE);
    mosi_d = shift_d[DATA_WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      done_cnt_q <= '0;
      tx_rd_en_q <= 1'b0;
      rx_wr_en_q <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      done_cnt_q <= done_cnt_d;
      tx_rd_en_q <= tx_rd_en_d;
      rx_wr_en_q <= rx_wr_en_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      mosi_q     <= mosi_d;
    end
  end

  assign tx_rd_en = tx_rd_en_q;
  assign rx_wr_en = rx_wr_en_q;
  assign rx_data  = rx_data_q;
  assign cs_n     = cs_n_q;
  assign busy     = busy_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: acts as TX FIFO, RX FIFO and SPI slave.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       loopback;
  logic [7:0] tx_data;
  logic       tx_empty;
  logic       tx_rd_en;
  logic [7:0] rx_data;
  logic       rx_full;
  logic       rx_wr_en;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  txq[$];
  logic [7:0]  miso_pat;
  int          miso_idx;
  logic [31:0] mosi_cap;
  logic [7:0]  last_rx;
  int          tx_rd_cnt, rx_wr_cnt, rise_cnt, csn_low, csn_rise, sclk_high, rd_viol, wr_viol;
  logic        prev_sclk, prev_csn;

  spi_master_ctrl #(
    .DATA_WIDTH (8),
    .CLK_DIV    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
`ifdef SPI_CTRL_LOOPBACK_EN
    .loopback (loopback),
`endif
    .tx_data  (tx_data),
    .tx_empty (tx_empty),
    .tx_rd_en (tx_rd_en),
    .rx_data  (rx_data),
    .rx_full  (rx_full),
    .rx_wr_en (rx_wr_en),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .cs_n     (cs_n),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_sync();
    tx_empty = (txq.size() == 0);
    tx_data  = tx_empty ? 8'h00 : txq[0];
  endtask

  task automatic clear_mon();
    miso_idx  = 0;
    mosi_cap  = '0;
    tx_rd_cnt = 0;
    rx_wr_cnt = 0;
    rise_cnt  = 0;
    csn_low   = 0;
    csn_rise  = 0;
    sclk_high = 0;
    rd_viol   = 0;
    wr_viol   = 0;
    miso      = miso_pat[7];
  endtask

  // One clock of FIFO / slave behaviour, observed on the falling clk edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_rd_en && tx_empty) rd_viol++;
      if (rx_wr_en && rx_full) wr_viol++;
      if (tx_rd_en) begin
        tx_rd_cnt++;
        if (txq.size() != 0) txq.delete(0);
        fifo_sync();
      end
      if (rx_wr_en) begin
        rx_wr_cnt++;
        last_rx = rx_data;
      end
      if (!cs_n) csn_low++;
      if (cs_n && !prev_csn) csn_rise++;
      if (sclk) sclk_high++;
      if (sclk && !prev_sclk) begin
        mosi_cap = {mosi_cap[30:0], mosi};
        rise_cnt++;
      end
      if (!sclk && prev_sclk) miso_idx++;
      miso      = miso_pat[3'(7 - (miso_idx % 8))];
      prev_sclk = sclk;
      prev_csn  = cs_n;
    end
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    loopback  = 1'b0;
    rx_full   = 1'b0;
    miso_pat  = 8'h00;
    last_rx   = 8'h00;
    prev_sclk = 1'b0;
    prev_csn  = 1'b1;
    fifo_sync();
    clear_mon();

    // Reset state
    step(3);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_rd_en", 32'(tx_rd_en), 32'd0);
    check("rst_rx_wr_en", 32'(rx_wr_en), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    rst = 1'b0;
    step(2);

    // Single word 0xA5 out, slave returns 0x3C
    txq = '{8'hA5};
    fifo_sync();
    miso_pat = 8'h3C;
    clear_mon();
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    check("single_busy_load", 32'(busy), 32'd1);
    check("single_tx_rd_en", 32'(tx_rd_en), 32'd1);
    step(89);
    check("single_mosi_bits", mosi_cap, 32'h0000_00A5);
    check("single_rises", 32'(rise_cnt), 32'd8);
    check("single_rd_cnt", 32'(tx_rd_cnt), 32'd1);
    check("single_wr_cnt", 32'(rx_wr_cnt), 32'd1);
    check("single_rx_data", 32'(last_rx), 32'h3C);
    check("single_cs_low", 32'(csn_low), 32'd70);
    check("single_idle_busy", 32'(busy), 32'd0);
    check("single_idle_cs_n", 32'(cs_n), 32'd1);
    step(10);
    check("rx_data_hold", 32'(rx_data), 32'h3C);

    // Back-to-back three words with enable held
    txq = '{8'h01, 8'h02, 8'h03};
    fifo_sync();
    miso_pat = 8'h96;
    clear_mon();
    enable = 1'b1;
    step(260);
    enable = 1'b0;
    check("b2b_mosi_bits", mosi_cap, 32'h0001_0203);
    check("b2b_rd_cnt", 32'(tx_rd_cnt), 32'd3);
    check("b2b_wr_cnt", 32'(rx_wr_cnt), 32'd3);
    check("b2b_rx_data", 32'(last_rx), 32'h96);
    check("b2b_cs_low", 32'(csn_low), 32'd202);
    check("b2b_cs_rises", 32'(csn_rise), 32'd1);
    check("b2b_rd_viol", 32'(rd_viol), 32'd0);

    // RX full stall in STORE
    txq = '{8'hC3};
    fifo_sync();
    miso_pat = 8'h5A;
    rx_full  = 1'b1;
    clear_mon();
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    step(64);
    sclk_high = 0;
    step(20);
    check("full_sclk_static", 32'(sclk_high), 32'd0);
    check("full_cs_n", 32'(cs_n), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    check("full_no_wr", 32'(rx_wr_cnt), 32'd0);
    rx_full = 1'b0;
    step(1);
    check("full_wr_after_drop", 32'(rx_wr_en), 32'd1);
    check("full_rx_data", 32'(rx_data), 32'h5A);
    step(1);
    check("full_wr_one_cycle", 32'(rx_wr_en), 32'd0);
    step(10);
    check("full_done_cs_n", 32'(cs_n), 32'd1);
    check("full_wr_viol", 32'(wr_viol), 32'd0);

    // Reset in the middle of a word
    txq = '{8'hFF};
    fifo_sync();
    miso_pat = 8'hFF;
    clear_mon();
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    step(32);
    check("midrst_bit4", 32'(rise_cnt), 32'd4);
    rst = 1'b1;
    step(1);
    check("midrst_cs_n", 32'(cs_n), 32'd1);
    check("midrst_sclk", 32'(sclk), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step(80);
    check("midrst_no_wr", 32'(rx_wr_cnt), 32'd0);
    check("midrst_idle_cs_n", 32'(cs_n), 32'd1);

    // Enable with an empty TX FIFO
    txq.delete();
    fifo_sync();
    clear_mon();
    enable = 1'b1;
    step(50);
    enable = 1'b0;
    check("empty_busy", 32'(busy), 32'd0);
    check("empty_cs_n", 32'(cs_n), 32'd1);
    check("empty_no_rd", 32'(tx_rd_cnt), 32'd0);
    check("empty_cs_low", 32'(csn_low), 32'd0);

`ifdef SPI_CTRL_LOOPBACK_EN
    // Loopback returns the transmitted word regardless of miso
    txq = '{8'h5A};
    fifo_sync();
    miso_pat = 8'h00;
    loopback = 1'b1;
    clear_mon();
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    step(89);
    check("loop_rx_data", 32'(last_rx), 32'h5A);
    check("loop_wr_cnt", 32'(rx_wr_cnt), 32'd1);
    loopback = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
